serv_wb_ext_decoder: RTL

Parametrised successor to the fixed single-slave extension bus on the SERV core wrapper. Sits between the servile extension master (stb-only Wishbone, 0x4000_0000+ window) and NSLAVES peripheral slaves. Decodes addresses, registers the request, and sequences one transaction at a time. Adds a bus-timeout watchdog, unmapped-address handling and sticky fault capture, none of which the current direct tie-through has.

---
 rtl/serv_wb_pkg.sv | 18 +
 rtl/serv_wb_sat_ctr.sv | 27 ++
 rtl/serv_wb_ext_decoder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serv_wb_pkg.sv
// rtl/serv_wb_pkg.sv - shared types and constants for the servile extension-bus decoder
package serv_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [3:0]  DEF_BASE_NIB      = 4'h4;
   localparam logic [31:0] DEF_UNMAPPED_DATA = 32'hDEAD_BEEF;

   // Slave-index field width; never narrower than one bit so a single slave still decodes.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serv_wb_sat_ctr.sv
// rtl/serv_wb_sat_ctr.sv - saturating event counter, cleared by reset only
module serv_wb_sat_ctr
   import serv_wb_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/serv_wb_ext_decoder.sv
// rtl/serv_wb_ext_decoder.sv - one-at-a-time extension-bus decoder with watchdog and fault capture
// SERV_WB_EXT_STATS_EN builds the transaction/timeout counters; otherwise they read 0.
module serv_wb_ext_decoder
   import serv_wb_pkg::*;
#(
   parameter int          NSLAVES        = 4,
   parameter logic [3:0]  BASE_NIB       = DEF_BASE_NIB,
   parameter int          SLV_SHIFT      = 8,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] UNMAPPED_DATA  = DEF_UNMAPPED_DATA
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [31:0]             i_wb_adr,
   input  logic [31:0]             i_wb_dat,
   input  logic [3:0]              i_wb_sel,
   input  logic                    i_wb_we,
   input  logic                    i_wb_stb,
   output logic [31:0]             o_wb_rdt,
   output logic                    o_wb_ack,
   output logic [31:0]             o_s_adr,
   output logic [31:0]             o_s_dat,
   output logic [3:0]              o_s_sel,
   output logic                    o_s_we,
   output logic [NSLAVES-1:0]      o_s_stb,
   output logic [NSLAVES-1:0]      o_s_cyc,
   input  logic [NSLAVES*32-1:0]   i_s_rdt,
   input  logic [NSLAVES-1:0]      i_s_ack,
   output logic                    o_fault,
   output logic [31:0]             o_fault_adr,
   input  logic                    i_fault_clr,
   output logic [15:0]             o_txn_cnt,
   output logic [15:0]             o_tmo_cnt
);

   localparam int IDXW = idx_w(NSLAVES);
   localparam int WDW  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] TMO_VAL = WDW'(TIMEOUT_CYCLES);
   localparam logic [IDXW:0]  NS_VAL  = (IDXW + 1)'(NSLAVES);

   state_e              state_q, state_d;
   logic [31:0]         adr_q, adr_d, dat_q, dat_d, rdt_q, rdt_d, fadr_q, fadr_d;
   logic [3:0]          sel_q, sel_d;
   logic                we_q, we_d, fault_q, fault_d;
   logic [NSLAVES-1:0]  stb_q, stb_d;
   logic [WDW-1:0]      wd_q, wd_d;

   logic [IDXW-1:0]     req_idx;
   logic                req_mapped;
   logic [NSLAVES-1:0]  req_onehot;
   logic                slv_ack, wd_expired, fault_evt;
   logic [31:0]         slv_rdt, fault_evt_adr;

   assign req_idx    = i_wb_adr[SLV_SHIFT +: IDXW];
   assign req_mapped = (i_wb_adr[31:28] == BASE_NIB) && ({1'b0, req_idx} < NS_VAL);
   // The strobe register is one-hot on the active slave, so masking with it ignores stray acks.
   assign slv_ack    = |(i_s_ack & stb_q);
   assign wd_expired = (TIMEOUT_CYCLES != 0) && ((wd_q + 1'b1) == TMO_VAL);

   always_comb begin
      req_onehot = '0;
      slv_rdt    = '0;
      for (int k = 0; k < NSLAVES; k++) begin
         if (req_idx == IDXW'(k)) req_onehot[k] = 1'b1;
         if (stb_q[k])            slv_rdt = i_s_rdt[32*k +: 32];
      end
   end

   always_comb begin
      state_d       = state_q;
      adr_d         = adr_q;
      dat_d         = dat_q;
      sel_d         = sel_q;
      we_d          = we_q;
      stb_d         = stb_q;
      wd_d          = wd_q;
      rdt_d         = rdt_q;
      fault_evt     = 1'b0;
      fault_evt_adr = adr_q;
      case (state_q)
         ST_IDLE: begin
            if (i_wb_stb) begin
               adr_d = i_wb_adr;
               dat_d = i_wb_dat;
               sel_d = i_wb_sel;
               we_d  = i_wb_we;
               if (req_mapped) begin
                  stb_d   = req_onehot;
                  wd_d    = '0;
                  state_d = ST_BUSY;
               end else begin
                  rdt_d         = UNMAPPED_DATA;
                  fault_evt     = 1'b1;
                  fault_evt_adr = i_wb_adr;
                  state_d       = ST_RESP;
               end
            end
         end
         ST_BUSY: begin
            if (slv_ack) begin
               rdt_d   = slv_rdt;
               stb_d   = '0;
               state_d = ST_RESP;
            end else if (wd_expired) begin
               rdt_d     = UNMAPPED_DATA;
               stb_d     = '0;
               fault_evt = 1'b1;
               state_d   = ST_RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A fault in the same cycle as a clear survives it; otherwise the first fault address sticks.
   always_comb begin
      fault_d = fault_q;
      fadr_d  = fadr_q;
      if (i_fault_clr) begin
         fault_d = 1'b0;
         fadr_d  = '0;
      end
      if (fault_evt) begin
         fault_d = 1'b1;
         if (!fault_q || i_fault_clr) fadr_d = fault_evt_adr;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         stb_q   <= '0;
         wd_q    <= '0;
         rdt_q   <= '0;
         fault_q <= 1'b0;
         fadr_q  <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         stb_q   <= stb_d;
         wd_q    <= wd_d;
         rdt_q   <= rdt_d;
         fault_q <= fault_d;
         fadr_q  <= fadr_d;
      end
   end

   assign o_wb_ack    = (state_q == ST_RESP);
   assign o_wb_rdt    = rdt_q;
   assign o_s_adr     = adr_q;
   assign o_s_dat     = dat_q;
   assign o_s_sel     = sel_q;
   assign o_s_we      = we_q;
   assign o_s_stb     = stb_q;
   assign o_s_cyc     = stb_q;
   assign o_fault     = fault_q;
   assign o_fault_adr = fadr_q;

`ifdef SERV_WB_EXT_STATS_EN
   logic tmo_evt;
   assign tmo_evt = (state_q == ST_BUSY) && !slv_ack && wd_expired;

   serv_wb_sat_ctr #(.W(16)) u_txn_ctr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (o_wb_ack),
      .o_cnt   (o_txn_cnt)
   );

   serv_wb_sat_ctr #(.W(16)) u_tmo_ctr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_inc   (tmo_evt),
      .o_cnt   (o_tmo_cnt)
   );
`else
   assign o_txn_cnt = '0;
   assign o_tmo_cnt = '0;
`endif

endmodule
